shift_left_right_register: RTL and testbench
============================================

Name: shift_left_right_register

Overview:
- Parallel-load, bidirectional shift register of WIDTH bits.
- Each clock it either loads the parallel input or shifts the held word left or right by one bit.
- Intended as a generic datapath building block, e.g. for serializers, bit-manipulation pipelines and test-pattern generation.
- Single clock domain; output is the register contents directly, with no combinational path from inputs.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- i  input  WIDTH  parallel load data
- load_enable  input  1  1 = load i this cycle; 0 = shift this cycle
- shift_left_right  input  1  shift direction when not loading; 0 = left (toward MSB), 1 = right (toward LSB)
- q  output  WIDTH  registered contents

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All state updates occur on the rising edge of clk. q is driven straight from the flops.
- Priority at each rising edge, highest first: reset, then load, then shift.
  - reset = 1: q <= 0. This overrides load_enable and shift_left_right.
  - reset = 0, load_enable = 1: q <= i. Latency is one cycle; q shows i after the edge. shift_left_right is ignored.
  - reset = 0, load_enable = 0, shift_left_right = 0: q <= {q[WIDTH-2:0], 1'b0}. The MSB is discarded and the LSB is zero-filled.
  - reset = 0, load_enable = 0, shift_left_right = 1: q <= {1'b0, q[WIDTH-1:1]}. The LSB is discarded and the MSB is zero-filled.
- There is no hold state. Every non-reset, non-load cycle shifts. Upstream logic must keep load_enable = 1 with stable i to hold a value.
- Once q = 0, continued shifting in either direction keeps q = 0.
- After WIDTH consecutive shifts in one direction, q = 0 regardless of its starting value.
- Reset asserted mid-sequence clears q on the next edge. The following non-reset cycle resumes normal load/shift operation.
- Before the first reset, q is X in simulation. No initial value is required.
- Inputs are sampled only at the rising edge. Changes between edges have no effect.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- When defined, shifts become rotates: left gives q <= {q[WIDTH-2:0], q[WIDTH-1]}; right gives q <= {q[0], q[WIDTH-1:1]}.
- When undefined, shifts are zero-fill as described in Behaviour.
- Load and reset behaviour are identical in both builds.

Decomposition:
- Shared package shift_reg_pkg holds:
  - direction constants SHIFT_LEFT = 1'b0 and SHIFT_RIGHT = 1'b1;
  - default width constant SHIFT_REG_DEFAULT_WIDTH = 8.
- No sub-module. The next-state mux and flop bank sit in one module, with next-state logic in a single combinational block feeding one clocked block.

Test Plan:
1. Reset: drive reset=1 with i=8'hFF and load_enable=1, then clock -> q=8'h00. Release reset with load_enable=0 and clock 3 edges -> q stays 8'h00.
2. Load and hold: i=8'hFF, load_enable=1 for 5 edges -> q=8'hFF after the first edge and stays 8'hFF. Change i to 8'hA8 while load_enable=1 -> q=8'hA8 on the next edge.
3. Left shift: load 8'hFF, then load_enable=0, shift_left_right=0 -> q goes 8'hFE, 8'hFC, 8'hF8 ... 8'h00 after 8 edges. With SHIFT_ROTATE_EN defined, loading 8'h81 then shifting left gives 8'h03 then 8'h06.
4. Right shift: load 8'hA8, then load_enable=0, shift_left_right=1 -> q goes 8'h54, 8'h2A, 8'h15, 8'h0A ... 8'h00. With SHIFT_ROTATE_EN defined, loading 8'h81 then shifting right gives 8'hC0.
5. Direction change and priority: load 8'h18, shift left once (8'h30), then right twice (8'h18, 8'h0C). Then raise load_enable=1 with shift_left_right=1 and i=8'h5A -> q=8'h5A (load wins).
6. Reset mid-shift: load 8'hFF, shift left 2 edges (8'hFC), assert reset for 1 edge -> q=8'h00. Deassert reset with load_enable=1 and i=8'h3C -> q=8'h3C.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared constants for the bidirectional shift register.
// Direction encoding matches the shift_left_right port: 0 shifts toward the
// MSB, 1 shifts toward the LSB.
package shift_reg_pkg;

   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   localparam int SHIFT_REG_DEFAULT_WIDTH = 8;

endpackage : shift_reg_pkg

// File: rtl/shift_left_right_register.sv
// Parallel-load, bidirectional shift register of WIDTH bits.
// Each clock either loads i or shifts the held word one bit left or right.
// There is no hold state; holding a value means keeping load_enable high.
// Optional macro SHIFT_ROTATE_EN: when defined, shifts wrap the outgoing bit
// around to the opposite end instead of zero-filling.
module shift_left_right_register
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i,
   input  logic             load_enable,
   input  logic             shift_left_right,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next-state mux: load has priority over shifting; reset is applied in the flop stage.
   always_comb begin
      q_d = q_q;
      if (load_enable) begin
         q_d = i;
      end else begin
         case (shift_left_right)
`ifdef SHIFT_ROTATE_EN
            SHIFT_LEFT:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            SHIFT_RIGHT: q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
            SHIFT_LEFT:  q_d = {q_q[WIDTH-2:0], 1'b0};
            SHIFT_RIGHT: q_d = {1'b0, q_q[WIDTH-1:1]};
`endif
            default:     q_d = q_q;
         endcase
      end
   end

   // Register bank with synchronous clear that overrides load and shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : shift_left_right_register

// File: tb/tb_shift_left_right_register.sv
// Self-checking bench for shift_left_right_register (WIDTH = 8).
// Expected words come from a behavioural model and are queued when each
// vector is driven, then popped and compared after the clock edge.
// Honours SHIFT_ROTATE_EN so the same bench covers both builds.
module tb_shift_left_right_register;

   localparam int W = 8;

   typedef struct packed {
      logic         rst;
      logic         le;
      logic         dir;
      logic [W-1:0] din;
   } stim_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] i = '0;
   logic         load_enable = 1'b0;
   logic         shift_left_right = 1'b0;
   logic [W-1:0] q;

   logic [W-1:0] model_q;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] expected;
   int           vectors = 0;
   int           miscompares = 0;

   shift_left_right_register #(.WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .i                (i),
      .load_enable      (load_enable),
      .shift_left_right (shift_left_right),
      .q                (q)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference behaviour of one clock edge.
   function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic r,
                                               input logic le, input logic dir,
                                               input logic [W-1:0] din);
      if (r) return '0;
      if (le) return din;
`ifdef SHIFT_ROTATE_EN
      if (dir) return (cur >> 1) | (cur << (W - 1));
      return (cur << 1) | (cur >> (W - 1));
`else
      if (dir) return cur >> 1;
      return cur << 1;
`endif
   endfunction

   // Drive one vector away from the edge, queue its expected result, then step past the edge.
   task automatic applyStimulus(input stim_t s);
      reset            = s.rst;
      load_enable      = s.le;
      shift_left_right = s.dir;
      i                = s.din;
      model_q          = model_next(model_q, s.rst, s.le, s.dir, s.din);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      stim_t tbl [4];
      tbl = '{'{1'b1, 1'b1, 1'b0, 8'hFF},
              '{1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b0, 1'b0, 1'b0, 8'h00}};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL reset step %0d: q=%h expected=%h", k, q, expected);
         end
         vectors++;
         if (q !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_zero step %0d: q=%h expected=00", k, q);
         end
      end
   endtask

   task automatic test_load_hold;
      stim_t tbl [6];
      tbl = '{'{1'b0, 1'b1, 1'b0, 8'hFF}, '{1'b0, 1'b1, 1'b1, 8'hFF},
              '{1'b0, 1'b1, 1'b0, 8'hFF}, '{1'b0, 1'b1, 1'b1, 8'hFF},
              '{1'b0, 1'b1, 1'b0, 8'hFF}, '{1'b0, 1'b1, 1'b0, 8'hA8}};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL load_hold step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   task automatic test_left_shift;
      stim_t tbl [12];
      tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hFF};
      for (int k = 1; k <= 8; k++) tbl[k] = '{1'b0, 1'b0, 1'b0, 8'h00};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h81};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL left_shift step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   task automatic test_right_shift;
      stim_t tbl [12];
      tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hA8};
      for (int k = 1; k <= 8; k++) tbl[k] = '{1'b0, 1'b0, 1'b1, 8'hFF};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h81};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL right_shift step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   task automatic test_direction_priority;
      stim_t tbl [5];
      tbl = '{'{1'b0, 1'b1, 1'b0, 8'h18},
              '{1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b0, 1'b0, 1'b1, 8'h00},
              '{1'b0, 1'b0, 1'b1, 8'h00},
              '{1'b0, 1'b1, 1'b1, 8'h5A}};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL direction_priority step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   task automatic test_reset_mid_shift;
      stim_t tbl [6];
      tbl = '{'{1'b0, 1'b1, 1'b0, 8'hFF},
              '{1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b1, 1'b1, 1'b1, 8'h77},
              '{1'b0, 1'b1, 1'b0, 8'h3C},
              '{1'b0, 1'b0, 1'b1, 8'h00}};
      foreach (tbl[k]) begin
         applyStimulus(tbl[k]);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_shift step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   task automatic test_back_to_back;
      stim_t s;
      for (int k = 0; k < 60; k++) begin
         s.rst = ($urandom_range(0, 15) == 0);
         s.le  = ($urandom_range(0, 3) == 0);
         s.dir = 1'($urandom_range(0, 1));
         s.din = 8'($urandom);
         applyStimulus(s);
         expected = exp_q.pop_front();
         vectors++;
         if (q !== expected) begin
            miscompares++;
            $display("[TB] FAIL back_to_back step %0d: q=%h expected=%h", k, q, expected);
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      model_q = 'x;
      test_reset();
      test_load_hold();
      test_left_shift();
      test_right_shift();
      test_direction_priority();
      test_reset_mid_shift();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_shift_left_right_register
